sm4_mode_ctrl: RTL and testbench

Sequencing controller in front of the SM4 top-level core (key expansion plus encrypt/decrypt datapath).
- Accepts a user key, an optional IV and a stream of 128-bit blocks on valid/ready handshakes.
- Drives the core's key-expansion and block interfaces, and applies ECB or CBC chaining around the core.
- Returns results on a valid/ready output port, with one block in flight at a time.

---
 rtl/sm4_ctrl_pkg.sv | 18 +
 rtl/sm4_chain_unit.sv | 34 +++
 rtl/sm4_mode_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sm4_mode_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_ctrl_pkg.sv
// rtl/sm4_ctrl_pkg.sv - shared state encoding and constants for the SM4 mode controller
package sm4_ctrl_pkg;

  localparam int SM4_BLK_W   = 128;
  localparam int DEF_TIMEOUT = 256;
  localparam int DEF_TO_W    = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KREQ  = 3'd1,
    ST_KWAIT = 3'd2,
    ST_RDY   = 3'd3,
    ST_ISSUE = 3'd4,
    ST_WAIT  = 3'd5,
    ST_OUT   = 3'd6
  } state_t;

endpackage

// File: rtl/sm4_chain_unit.sv
// rtl/sm4_chain_unit.sv - CBC chain register with pre-core and post-core XOR muxing
module sm4_chain_unit
  import sm4_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode_cbc,
  input  logic                 decrypt,
  input  logic                 iv_wr,
  input  logic [SM4_BLK_W-1:0] iv,
  input  logic [SM4_BLK_W-1:0] in_blk,
  input  logic                 result_wr,
  input  logic [SM4_BLK_W-1:0] core_result,
  output logic [SM4_BLK_W-1:0] pre_data,
  output logic [SM4_BLK_W-1:0] post_data
);

  logic [SM4_BLK_W-1:0] chain;

  assign pre_data  = (mode_cbc && !decrypt) ? (in_blk ^ chain) : in_blk;
  assign post_data = (mode_cbc && decrypt) ? (core_result ^ chain) : core_result;

  // Encrypt chains on ciphertext out of the core; decrypt chains on ciphertext in.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else if (iv_wr) begin
      chain <= iv;
    end else if (result_wr && mode_cbc) begin
      chain <= decrypt ? in_blk : core_result;
    end
  end

endmodule

// File: rtl/sm4_mode_ctrl.sv
// rtl/sm4_mode_ctrl.sv - ECB/CBC sequencing controller for the SM4 core; optional blk_cnt_out via SM4_MODE_CTRL_BLKCNT_EN
module sm4_mode_ctrl
  import sm4_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int TO_W           = DEF_TO_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_load_in,
  input  logic [SM4_BLK_W-1:0] key_in,
  input  logic                 mode_cbc_in,
  input  logic                 encdec_sel_in,
  input  logic                 iv_load_in,
  input  logic [SM4_BLK_W-1:0] iv_in,
  input  logic                 blk_valid_in,
  input  logic [SM4_BLK_W-1:0] blk_data_in,
  output logic                 blk_ready_out,
  output logic                 res_valid_out,
  output logic [SM4_BLK_W-1:0] res_data_out,
  input  logic                 res_ready_in,
  output logic                 busy_out,
  output logic                 err_out,
  output logic                 core_sm4_enable_out,
  output logic                 core_encdec_enable_out,
  output logic                 core_encdec_sel_out,
  output logic                 core_enable_key_exp_out,
  output logic                 core_user_key_valid_out,
  output logic [SM4_BLK_W-1:0] core_user_key_out,
  input  logic                 core_key_exp_ready_in,
  output logic                 core_valid_out,
  output logic [SM4_BLK_W-1:0] core_data_out,
  input  logic                 core_ready_in,
  input  logic [SM4_BLK_W-1:0] core_result_in
`ifdef SM4_MODE_CTRL_BLKCNT_EN
  ,
  output logic [31:0]          blk_cnt_out
`endif
);

  state_t               state, state_nxt;
  logic [TO_W-1:0]      to_cnt;
  logic                 err_reg;
  logic                 cbc_reg;
  logic                 dec_reg;
  logic [SM4_BLK_W-1:0] key_reg;
  logic [SM4_BLK_W-1:0] in_reg;
  logic [SM4_BLK_W-1:0] res_reg;
  logic [SM4_BLK_W-1:0] pre_data;
  logic [SM4_BLK_W-1:0] post_data;
  logic                 cfg_state;
  logic                 key_acc;
  logic                 iv_acc;
  logic                 blk_acc;
  logic                 res_cap;
  logic                 to_hit;
  logic                 to_abort;

  assign cfg_state = (state == ST_IDLE) || (state == ST_RDY);
  assign key_acc   = key_load_in && cfg_state;
  assign iv_acc    = iv_load_in && cfg_state;
  assign blk_acc   = (state == ST_RDY) && blk_valid_in && !key_load_in;
  assign res_cap   = (state == ST_WAIT) && core_ready_in;
  assign to_hit    = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign to_abort  = to_hit && (((state == ST_KWAIT) && !core_key_exp_ready_in) ||
                                ((state == ST_WAIT) && !core_ready_in));

  sm4_chain_unit u_chain (
    .clk         (clk),
    .reset       (reset),
    .mode_cbc    (cbc_reg),
    .decrypt     (dec_reg),
    .iv_wr       (iv_acc),
    .iv          (iv_in),
    .in_blk      (in_reg),
    .result_wr   (res_cap),
    .core_result (core_result_in),
    .pre_data    (pre_data),
    .post_data   (post_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt               = state;
    blk_ready_out           = 1'b0;
    res_valid_out           = 1'b0;
    core_user_key_valid_out = 1'b0;
    core_enable_key_exp_out = 1'b0;
    core_encdec_enable_out  = 1'b0;
    core_valid_out          = 1'b0;
    core_sm4_enable_out     = (state != ST_IDLE);
    busy_out                = (state != ST_IDLE) && (state != ST_RDY);
    case (state)
      ST_IDLE: begin
        if (key_load_in) state_nxt = ST_KREQ;
      end
      ST_KREQ: begin
        core_user_key_valid_out = 1'b1;
        core_enable_key_exp_out = 1'b1;
        state_nxt               = ST_KWAIT;
      end
      ST_KWAIT: begin
        core_enable_key_exp_out = 1'b1;
        if (core_key_exp_ready_in) state_nxt = ST_RDY;
        else if (to_hit)           state_nxt = ST_IDLE;
      end
      ST_RDY: begin
        // Ready drops while a key load is pending so a block is never half-accepted.
        blk_ready_out = !key_load_in;
        if (key_load_in)       state_nxt = ST_KREQ;
        else if (blk_valid_in) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        core_encdec_enable_out = 1'b1;
        core_valid_out         = 1'b1;
        state_nxt              = ST_WAIT;
      end
      ST_WAIT: begin
        core_encdec_enable_out = 1'b1;
        if (core_ready_in) state_nxt = ST_OUT;
        else if (to_hit)   state_nxt = ST_IDLE;
      end
      ST_OUT: begin
        res_valid_out = 1'b1;
        if (res_ready_in) state_nxt = ST_RDY;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt  <= '0;
      err_reg <= 1'b0;
      cbc_reg <= 1'b0;
      dec_reg <= 1'b0;
      key_reg <= '0;
      in_reg  <= '0;
      res_reg <= '0;
    end else begin
      if (key_acc) begin
        key_reg <= key_in;
        cbc_reg <= mode_cbc_in;
        dec_reg <= encdec_sel_in;
        err_reg <= 1'b0;
      end else if (to_abort) begin
        err_reg <= 1'b1;
      end
      if ((state == ST_KREQ) || (state == ST_ISSUE)) begin
        to_cnt <= '0;
      end else if ((state == ST_KWAIT) || (state == ST_WAIT)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (blk_acc) in_reg <= blk_data_in;
      if (res_cap) res_reg <= post_data;
    end
  end

  assign res_data_out        = res_reg;
  assign err_out             = err_reg;
  assign core_encdec_sel_out = dec_reg;
  assign core_user_key_out   = key_reg;
  assign core_data_out       = pre_data;

`ifdef SM4_MODE_CTRL_BLKCNT_EN
  logic [31:0] blk_cnt;

  always_ff @(posedge clk) begin
    if (reset || key_acc || iv_acc) begin
      blk_cnt <= '0;
    end else if ((state == ST_OUT) && res_ready_in) begin
      blk_cnt <= blk_cnt + 32'd1;
    end
  end

  assign blk_cnt_out = blk_cnt;
`endif

endmodule

// File: tb/tb_sm4_mode_ctrl.sv
// tb/tb_sm4_mode_ctrl.sv - self-checking bench for sm4_mode_ctrl with a behavioural core model
module tb_sm4_mode_ctrl;

  localparam logic [127:0] KEY_K = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT_K  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] IV_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] TOY_C = 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_load_in = 1'b0;
  logic [127:0] key_in = '0;
  logic         mode_cbc_in = 1'b0;
  logic         encdec_sel_in = 1'b0;
  logic         iv_load_in = 1'b0;
  logic [127:0] iv_in = '0;
  logic         blk_valid_in = 1'b0;
  logic [127:0] blk_data_in = '0;
  logic         blk_ready_out;
  logic         res_valid_out;
  logic [127:0] res_data_out;
  logic         res_ready_in = 1'b0;
  logic         busy_out;
  logic         err_out;
  logic         core_sm4_enable_out;
  logic         core_encdec_enable_out;
  logic         core_encdec_sel_out;
  logic         core_enable_key_exp_out;
  logic         core_user_key_valid_out;
  logic [127:0] core_user_key_out;
  logic         core_key_exp_ready_in = 1'b0;
  logic         core_valid_out;
  logic [127:0] core_data_out;
  logic         core_ready_in = 1'b0;
  logic [127:0] core_result_in = '0;

  int passed = 0;
  int total  = 0;

  // Core model knobs and observation state
  bit           core_silent = 1'b0;
  int           force_lat = -1;
  int           last_lat = 0;
  int           valid_cnt = 0;
  bit           pend = 1'b0;
  int           pend_cnt = 0;
  logic [127:0] pend_res = '0;
  int           kexp_cnt = 0;

  always #5 clk = ~clk;

  sm4_mode_ctrl dut (
    .clk                     (clk),
    .reset                   (reset),
    .key_load_in             (key_load_in),
    .key_in                  (key_in),
    .mode_cbc_in             (mode_cbc_in),
    .encdec_sel_in           (encdec_sel_in),
    .iv_load_in              (iv_load_in),
    .iv_in                   (iv_in),
    .blk_valid_in            (blk_valid_in),
    .blk_data_in             (blk_data_in),
    .blk_ready_out           (blk_ready_out),
    .res_valid_out           (res_valid_out),
    .res_data_out            (res_data_out),
    .res_ready_in            (res_ready_in),
    .busy_out                (busy_out),
    .err_out                 (err_out),
    .core_sm4_enable_out     (core_sm4_enable_out),
    .core_encdec_enable_out  (core_encdec_enable_out),
    .core_encdec_sel_out     (core_encdec_sel_out),
    .core_enable_key_exp_out (core_enable_key_exp_out),
    .core_user_key_valid_out (core_user_key_valid_out),
    .core_user_key_out       (core_user_key_out),
    .core_key_exp_ready_in   (core_key_exp_ready_in),
    .core_valid_out          (core_valid_out),
    .core_data_out           (core_data_out),
    .core_ready_in           (core_ready_in),
    .core_result_in          (core_result_in)
  );

  // Stand-in cipher: the published SM4 vector for the reference key, an invertible toy otherwise.
  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] x, input logic dec);
    logic [127:0] z;
    if (k == KEY_K && !dec && x == KEY_K) return CT_K;
    if (k == KEY_K && dec && x == CT_K) return KEY_K;
    if (!dec) return {x[126:0], x[127]} ^ k ^ TOY_C;
    z = x ^ k ^ TOY_C;
    return {z[0], z[127:1]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    core_ready_in = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        core_ready_in  = 1'b1;
        core_result_in = pend_res;
        pend           = 1'b0;
      end else begin
        pend_cnt = pend_cnt - 1;
      end
    end
    if (core_valid_out) begin
      valid_cnt = valid_cnt + 1;
      if (!core_silent) begin
        last_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
        pend     = 1'b1;
        pend_cnt = last_lat;
        pend_res = core_f(core_user_key_out, core_data_out, core_encdec_sel_out);
      end
    end
    if (core_user_key_valid_out) begin
      core_key_exp_ready_in = 1'b0;
      kexp_cnt              = 3;
    end else if (kexp_cnt > 0) begin
      kexp_cnt = kexp_cnt - 1;
      if (kexp_cnt == 0) core_key_exp_ready_in = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic load_key(input logic [127:0] k, input logic cbc, input logic dec);
    int n;
    key_in = k; mode_cbc_in = cbc; encdec_sel_in = dec; key_load_in = 1'b1;
    step();
    key_load_in = 1'b0;
    chk("kreq_key_valid", core_user_key_valid_out, 1);
    chk("kreq_key", core_user_key_out, k);
    n = 0;
    while (!blk_ready_out && n < 50) begin step(); n++; end
    chk("key_ready", blk_ready_out, 1);
    chk("key_sel", core_encdec_sel_out, dec);
  endtask

  task automatic load_iv(input logic [127:0] iv);
    iv_in = iv; iv_load_in = 1'b1;
    step();
    iv_load_in = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] data, input logic [127:0] exp_in,
                            input logic [127:0] exp_res, input int bp,
                            input bit with_iv, input logic [127:0] iv);
    int n;
    int vc;
    logic [127:0] key_hold;
    key_hold = core_user_key_out;
    blk_valid_in = 1'b1; blk_data_in = data;
    if (with_iv) begin iv_load_in = 1'b1; iv_in = iv; end
    chk("blk_ready", blk_ready_out, 1);
    step();
    blk_valid_in = 1'b0; iv_load_in = 1'b0;
    chk("issue_valid", core_valid_out, 1);
    chk("issue_data", core_data_out, exp_in);
    n = 0;
    while (!res_valid_out && n < 50) begin step(); n++; end
    chk("res_valid", res_valid_out, 1);
    chk("turnaround", n, last_lat + 2);
    chk("res_data", res_data_out, exp_res);
    vc = valid_cnt;
    for (int i = 0; i < bp; i++) begin
      key_load_in = 1'b1; key_in = rnd128();
      iv_load_in = 1'b1; iv_in = rnd128();
      blk_valid_in = 1'b1; blk_data_in = rnd128();
      step();
      chk("bp_res_data", res_data_out, exp_res);
      chk("bp_blk_ready", blk_ready_out, 0);
      chk("bp_res_valid", res_valid_out, 1);
    end
    key_load_in = 1'b0; iv_load_in = 1'b0; blk_valid_in = 1'b0;
    chk("bp_no_core_valid", valid_cnt, vc);
    chk("bp_key_kept", core_user_key_out, key_hold);
    res_ready_in = 1'b1;
    step();
    res_ready_in = 1'b0;
    chk("post_res_valid", res_valid_out, 0);
    chk("post_blk_ready", blk_ready_out, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, iv, p, prev, e_in, e_res, c1, c2, p1, p2;
    logic cbc, dec;
    bit use_iv_blk;
    int n;

    reset = 1'b1;
    repeat (3) step();
    chk("rst_res_valid", res_valid_out, 0);
    chk("rst_blk_ready", blk_ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_sm4_en", core_sm4_enable_out, 0);
    chk("rst_core_data", core_data_out, 0);
    chk("rst_user_key", core_user_key_out, 0);
    chk("rst_res_data", res_data_out, 0);
    reset = 1'b0;
    step();
    blk_valid_in = 1'b1;
    step();
    chk("idle_no_accept", blk_ready_out, 0);
    chk("idle_no_issue", core_valid_out, 0);
    blk_valid_in = 1'b0;

    // Known-answer ECB encrypt and decrypt
    load_key(KEY_K, 1'b0, 1'b0);
    send_block(KEY_K, KEY_K, CT_K, 0, 1'b0, '0);
    load_key(KEY_K, 1'b0, 1'b1);
    send_block(CT_K, CT_K, KEY_K, 1, 1'b0, '0);

    // CBC encrypt two blocks, then decrypt them back
    p1 = rnd128(); p2 = rnd128();
    load_key(KEY_K, 1'b1, 1'b0);
    load_iv(IV_K);
    c1 = core_f(KEY_K, p1 ^ IV_K, 1'b0);
    send_block(p1, p1 ^ IV_K, c1, 2, 1'b0, '0);
    c2 = core_f(KEY_K, p2 ^ c1, 1'b0);
    send_block(p2, p2 ^ c1, c2, 0, 1'b0, '0);
    load_key(KEY_K, 1'b1, 1'b1);
    load_iv(IV_K);
    send_block(c1, c1, p1, 0, 1'b0, '0);
    send_block(c2, c2, p2, 1, 1'b0, '0);

    // Randomised sessions against the chaining model
    for (int s = 0; s < 6; s++) begin
      k = rnd128(); iv = rnd128();
      cbc = 1'($urandom_range(0, 1)); dec = 1'($urandom_range(0, 1));
      use_iv_blk = 1'($urandom_range(0, 1));
      load_key(k, cbc, dec);
      if (!use_iv_blk) load_iv(iv);
      prev = iv;
      for (int b = 0; b < 4; b++) begin
        p = rnd128();
        if (!cbc) begin
          e_in = p; e_res = core_f(k, p, dec);
        end else if (!dec) begin
          e_in = p ^ prev; e_res = core_f(k, e_in, 1'b0); prev = e_res;
        end else begin
          e_in = p; e_res = core_f(k, p, 1'b1) ^ prev; prev = p;
        end
        send_block(p, e_in, e_res, (b == 1) ? 10 : int'($urandom_range(0, 3)),
                   use_iv_blk && (b == 0), iv);
      end
    end

    // Core never answers: abort after the WAIT budget, key reload clears the error
    load_key(KEY_K, 1'b0, 1'b0);
    core_silent = 1'b1;
    blk_valid_in = 1'b1; blk_data_in = rnd128();
    step();
    blk_valid_in = 1'b0;
    chk("to_issue", core_valid_out, 1);
    step();
    repeat (255) step();
    chk("to_err_early", err_out, 0);
    chk("to_busy_early", busy_out, 1);
    step();
    chk("to_err", err_out, 1);
    chk("to_idle_busy", busy_out, 0);
    chk("to_idle_sm4_en", core_sm4_enable_out, 0);
    core_silent = 1'b0;
    load_key(KEY_K, 1'b0, 1'b0);
    chk("to_err_cleared", err_out, 0);

    // Reset while waiting on the core; the late core response must be ignored
    force_lat = 10;
    blk_valid_in = 1'b1; blk_data_in = KEY_K;
    step();
    blk_valid_in = 1'b0;
    step();
    step();
    chk("rw_busy", busy_out, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_busy0", busy_out, 0);
    chk("rw_sm4_en0", core_sm4_enable_out, 0);
    chk("rw_encdec_en0", core_encdec_enable_out, 0);
    chk("rw_core_data0", core_data_out, 0);
    chk("rw_user_key0", core_user_key_out, 0);
    chk("rw_res_data0", res_data_out, 0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (res_valid_out || core_valid_out || core_user_key_valid_out || busy_out) n++;
    end
    chk("rw_quiet_after", n, 0);
    force_lat = -1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
